// File: rtl/screen_clear_engine_pkg.sv
// Shared types and constants for the screen clear engine.
//   state_t  : clear FSM states
//   colour_t : RGB565 fill colour
//   ROW_SHIFT/COL_SHIFT : byte-address placement of the y and x pixel coordinates
package screen_clear_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic [15:0] colour_t;

  localparam int ROW_SHIFT = 10;
  localparam int COL_SHIFT = 1;

endpackage

// File: rtl/screen_clear_engine_pixel_scan_counter.sv
// Raster x/y counter for the screen clear engine.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : synchronous return to (0,0)
//   advance      : step to the next pixel in raster order
//   x, y         : current pixel coordinate
//   wrap         : x is at the last pixel of the line
//   last         : (x,y) is the last pixel of the frame
// Stepping past the last pixel returns to (0,0).
module pixel_scan_counter #(
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int X_BITS = 9,
  parameter int Y_BITS = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              advance,
  output logic [X_BITS-1:0] x,
  output logic [Y_BITS-1:0] y,
  output logic              wrap,
  output logic              last
);

  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(H_RES - 1);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(V_RES - 1);

  assign wrap = (x == X_LAST);
  assign last = wrap && (y == Y_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (last) begin
        x <= '0;
        y <= '0;
      end else if (wrap) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/screen_clear_engine.sv
// Screen clear engine: fills the VGA pixel buffer with one RGB565 colour
// through a write-only Avalon-MM master when the PIO clear bit rises.
//   clk, reset_n     : clock, asynchronous active-low reset
//   cmd_word         : PIO command; bit0 clear request (edge), bit1 abort,
//                      [31:16] fill colour
//   avm_address      : byte address BASE_ADDR | (y << 10) | (x << 1)
//   avm_write        : write strobe
//   avm_writedata    : fill colour
//   avm_byteenable   : always both bytes
//   avm_waitrequest  : slave stall
//   busy             : clear in progress
//   done_pulse       : one-cycle pulse after a clear completes
// Optional macro SCREEN_CLEAR_ABORT_EN: cmd_word[1] in WRITE aborts the clear
// once the in-flight beat is accepted.
module screen_clear_engine
  import screen_clear_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hC800_0000,
  parameter int          H_RES     = 320,
  parameter int          V_RES     = 240,
  parameter int          X_BITS    = 9,
  parameter int          Y_BITS    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] cmd_word,
  output logic [31:0] avm_address,
  output logic        avm_write,
  output logic [15:0] avm_writedata,
  output logic [1:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done_pulse
);

  state_t            state, state_next;
  logic              prev_req;
  logic              pend, pend_next;
  colour_t           colour;
  logic              start;
  logic              accept;
  logic              load;
  logic              cnt_clear;
  logic              advance;
  logic              abort;
  logic [X_BITS-1:0] x;
  logic [Y_BITS-1:0] y;
  logic              wrap;
  logic              last;

  assign start = cmd_word[0] & ~prev_req;

`ifdef SCREEN_CLEAR_ABORT_EN
  // An abort seen while the beat is stalled is remembered until the beat lands.
  logic abort_hold;
  logic unused_cmd;
  assign unused_cmd = ^cmd_word[15:2];
  assign abort      = abort_hold | cmd_word[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      abort_hold <= 1'b0;
    end else begin
      abort_hold <= (state == WRITE) && (state_next == WRITE) && abort;
    end
  end
`else
  logic unused_cmd;
  assign unused_cmd = ^cmd_word[15:1];
  assign abort      = 1'b0;
`endif

  pixel_scan_counter #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .X_BITS (X_BITS),
    .Y_BITS (Y_BITS)
  ) u_scan (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (cnt_clear),
    .advance (advance),
    .x       (x),
    .y       (y),
    .wrap    (wrap),
    .last    (last)
  );

  // Master outputs derive from registered state/counters so they stay stable
  // while the slave stalls and drop asynchronously on reset.
  assign avm_write      = (state == WRITE);
  assign avm_address    = BASE_ADDR | (32'(y) << ROW_SHIFT) | (32'(x) << COL_SHIFT);
  assign avm_writedata  = colour;
  assign avm_byteenable = 2'b11;
  assign busy           = (state != IDLE);
  assign accept         = avm_write & ~avm_waitrequest;

  always_comb begin
    state_next = state;
    pend_next  = pend;
    load       = 1'b0;
    cnt_clear  = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (start || pend) begin
          state_next = WRITE;
          load       = 1'b1;
          cnt_clear  = 1'b1;
          pend_next  = 1'b0;
        end
      end
      WRITE: begin
        if (start) pend_next = 1'b1;
        if (accept) begin
          advance = 1'b1;
          if (abort) begin
            state_next = IDLE;
            pend_next  = 1'b0;
          end else if (last) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (start) pend_next = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      prev_req   <= 1'b0;
      pend       <= 1'b0;
      colour     <= '0;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_next;
      prev_req   <= cmd_word[0];
      pend       <= pend_next;
      done_pulse <= (state == DONE);
      if (load) colour <= cmd_word[31:16];
    end
  end

endmodule

// File: doc/screen_clear_engine.md
Name: screen_clear_engine

Overview:
- Consumes the 32-bit command word driven by the reset-screen PIO output register.
- On a rising edge of the clear bit it fills the whole VGA pixel buffer with one RGB565 colour, using a write-only Avalon-MM master into the pixel-buffer SDRAM/on-chip memory.
- Reports busy/done so LBM software and other masters can sequence around the clear.

Parameters:
- BASE_ADDR, 32'hC800_0000, pixel buffer base address.
- H_RES, 320, pixels per line.
- V_RES, 240, lines per frame.
- X_BITS, 9, width of the x counter; must satisfy 2**X_BITS >= H_RES.
- Y_BITS, 8, width of the y counter; must satisfy 2**Y_BITS >= V_RES.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_word  in  32  PIO out_port.
  - bit0 = clear request (rising-edge triggered).
  - bit1 = abort (optional feature only).
  - [31:16] = fill colour, RGB565.
- avm_address  out  32  byte address = BASE_ADDR | (y << 10) | (x << 1).
- avm_write  out  1  write strobe.
- avm_writedata  out  16  fill colour.
- avm_byteenable  out  2  constant 2'b11.
- avm_waitrequest  in  1  slave stall.
- busy  out  1  high while a clear is in progress.
- done_pulse  out  1  one-cycle pulse when a clear completes.

Behaviour:
- Reset (async assert, sync release): state = IDLE; x = y = 0; prev_req = 0; pend = 0; avm_write = 0; avm_address = BASE_ADDR; avm_writedata = 0; busy = 0; done_pulse = 0.
- Edge detect: prev_req <= cmd_word[0] every cycle. start = cmd_word[0] & ~prev_req. A level held high never retriggers.
- IDLE:
  - On start (or when pend = 1), go to WRITE on the next edge.
  - Latch colour = cmd_word[31:16]; clear pend; x = y = 0; busy = 1.
  - Latency: avm_write is first asserted 1 cycle after the cycle in which start is seen.
- WRITE:
  - avm_write = 1.
  - Address, data and write are held stable while avm_waitrequest = 1.
  - A beat is accepted when avm_write & ~avm_waitrequest.
  - On acceptance:
    - if x == H_RES-1: x = 0, y = y+1;
    - else x = x+1.
  - On acceptance of the beat at (H_RES-1, V_RES-1): go to DONE, deassert avm_write the same edge.
- DONE (1 cycle): done_pulse = 1, busy = 0, then go to IDLE.
- A start edge during WRITE or DONE sets pend; the colour is resampled when the pending clear begins. Multiple edges while busy collapse into one pending clear.
- Zero-wait throughput: one pixel per cycle. A full clear takes H_RES*V_RES WRITE cycles + 1 DONE cycle.
- Address arithmetic: y << 10 and x << 1 are zero-extended to 32 bits and ORed with BASE_ADDR. No carry into the base; the low 18 bits of BASE_ADDR must be 0.
- Reset asserted mid-clear: the transfer is dropped immediately; avm_write = 0 asynchronously; pend is lost.

Optional Feature:
- Macro SCREEN_CLEAR_ABORT_EN.
- Defined:
  - cmd_word[1] = 1 sampled in WRITE aborts the clear.
  - If the current beat is stalled (waitrequest = 1), it completes first; the FSM then goes to IDLE without a DONE cycle.
  - busy drops on the abort edge; done_pulse is not raised; pend is cleared.
  - Abort in IDLE has no effect.
- Not defined: cmd_word[1] is ignored and every clear runs to completion.

Decomposition:
- Package screen_clear_pkg holds:
  - state enum {IDLE, WRITE, DONE};
  - localparam ROW_SHIFT = 10, COL_SHIFT = 1;
  - RGB565 colour typedef (16 bits).
- One sub-module, pixel_scan_counter, is natural: an x/y raster counter with advance, wrap and last outputs. The FSM and Avalon master stay in the top.

Test Plan (H_RES=4, V_RES=2, BASE_ADDR=32'hC800_0000 unless noted):
- Reset release, then cmd_word=32'hF800_0001 with no waitrequest:
  - 8 beats at addresses C8000000, 02, 04, 06, C8000400, 402, 404, 406, all data F800;
  - done_pulse on cycle 10 after the edge cycle; busy high for cycles 1-9.
- Same stimulus with waitrequest high for 3 cycles on beat 2: address C8000002 and data are held for 4 cycles; the beat count is still 8.
- bit0 held high for 50 cycles: exactly one clear. Toggle 0→1 twice during the clear with colour 001F: a second clear of 001F follows the first done_pulse.
- Default parameters: the last beat goes to C803_BE7E (y=239, x=319); 76800 beats are counted.
- Reset pulsed at beat 3: avm_write drops asynchronously; busy = 0; no done_pulse is produced; the FSM idles afterwards.
- With SCREEN_CLEAR_ABORT_EN, set bit1 at beat 5: no further beats after the in-flight beat; busy = 0; done_pulse never asserted.
